// File: rtl/scan_code_digit_buffer.sv
// PS/2 scan-code filter and digit shift buffer for the 7-segment display path.
// Drops break (F0) and extended (E0) sequences, decodes digits, and handles backspace and Esc.
//
// state     | meaning
// S_IDLE    | waiting for a make code or prefix
// S_BREAK   | F0 seen, next byte is the released key
// S_EXT     | E0 seen, next byte is an extended key or F0
// S_EXT_BRK | E0 F0 seen, next byte is the released extended key
module scan_code_digit_buffer #(
   parameter int NUM_DIGITS    = 4,
   parameter int ACCEPT_KEYPAD = 1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [7:0]                          scan_code_in,
   input  logic                                scan_valid_in,
   output logic [4*NUM_DIGITS-1:0]             digits_out,
   output logic [$clog2(NUM_DIGITS+1)-1:0]     count_out,
   output logic                                digit_valid_out,
   output logic                                error_out
);

   localparam int BW = 4 * NUM_DIGITS;
   localparam int CW = $clog2(NUM_DIGITS + 1);

   localparam logic [7:0] C_BREAK = 8'hF0;
   localparam logic [7:0] C_EXT   = 8'hE0;
   localparam logic [7:0] C_BKSP  = 8'h66;
   localparam logic [7:0] C_ESC   = 8'h76;

   typedef enum logic [1:0] {S_IDLE, S_BREAK, S_EXT, S_EXT_BRK} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [BW-1:0]   r_buf;
   logic [BW-1:0]   w_buf_nxt;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_nxt;
   logic            r_dv;
   logic            r_err;
   logic            w_dv_nxt;
   logic            w_err_nxt;
   logic            w_hit;
   logic [3:0]      w_digit;
   logic            w_act;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (scan_valid_in) begin
         case (r_state)
            S_IDLE: begin
               if (scan_code_in == C_BREAK)    w_state_nxt = S_BREAK;
               else if (scan_code_in == C_EXT) w_state_nxt = S_EXT;
            end
            S_EXT:   w_state_nxt = (scan_code_in == C_BREAK) ? S_EXT_BRK : S_IDLE;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_hit   = 1'b1;
      w_digit = 4'h0;
      case (scan_code_in)
         8'h16: w_digit = 4'd1;
         8'h1E: w_digit = 4'd2;
         8'h26: w_digit = 4'd3;
         8'h25: w_digit = 4'd4;
         8'h2E: w_digit = 4'd5;
         8'h36: w_digit = 4'd6;
         8'h3D: w_digit = 4'd7;
         8'h3E: w_digit = 4'd8;
         8'h46: w_digit = 4'd9;
         8'h45: w_digit = 4'd0;
         default: w_hit = 1'b0;
      endcase
      if (ACCEPT_KEYPAD != 0) begin
         case (scan_code_in)
            8'h69: begin w_hit = 1'b1; w_digit = 4'd1; end
            8'h72: begin w_hit = 1'b1; w_digit = 4'd2; end
            8'h7A: begin w_hit = 1'b1; w_digit = 4'd3; end
            8'h6B: begin w_hit = 1'b1; w_digit = 4'd4; end
            8'h73: begin w_hit = 1'b1; w_digit = 4'd5; end
            8'h74: begin w_hit = 1'b1; w_digit = 4'd6; end
            8'h6C: begin w_hit = 1'b1; w_digit = 4'd7; end
            8'h75: begin w_hit = 1'b1; w_digit = 4'd8; end
            8'h7D: begin w_hit = 1'b1; w_digit = 4'd9; end
            8'h70: begin w_hit = 1'b1; w_digit = 4'd0; end
            default: ;
         endcase
      end
   end

   // Action table applies only to non-prefix bytes arriving in IDLE.
   assign w_act = scan_valid_in && (r_state == S_IDLE) &&
                  (scan_code_in != C_BREAK) && (scan_code_in != C_EXT);

   always_comb begin
      w_buf_nxt = r_buf;
      w_cnt_nxt = r_cnt;
      w_dv_nxt  = 1'b0;
      w_err_nxt = 1'b0;
      if (w_act) begin
         if (w_hit) begin
            w_buf_nxt = (r_buf << 4) | BW'(w_digit);
            if (r_cnt != CW'(NUM_DIGITS)) w_cnt_nxt = r_cnt + CW'(1);
            w_dv_nxt  = 1'b1;
         end else if (scan_code_in == C_BKSP) begin
            if (r_cnt != '0) begin
               w_buf_nxt = (r_buf >> 4) | (BW'(4'hF) << (BW - 4));
               w_cnt_nxt = r_cnt - CW'(1);
               w_dv_nxt  = 1'b1;
            end
         end else if (scan_code_in == C_ESC) begin
            w_buf_nxt = '1;
            w_cnt_nxt = '0;
            w_dv_nxt  = (r_cnt != '0);
         end else begin
            w_err_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_buf <= '1;
         r_cnt <= '0;
         r_dv  <= 1'b0;
         r_err <= 1'b0;
      end else begin
         r_buf <= w_buf_nxt;
         r_cnt <= w_cnt_nxt;
         r_dv  <= w_dv_nxt;
         r_err <= w_err_nxt;
      end
   end

   assign digits_out      = r_buf;
   assign count_out       = r_cnt;
   assign digit_valid_out = r_dv;
   assign error_out       = r_err;

endmodule

// File: tb/tb_scan_code_digit_buffer.sv
// Scoreboard bench: instance A decodes keypad codes, instance B does not.
// Expected pulses are queued by the stimulus and popped by per-instance monitors.
module tb_scan_code_digit_buffer;

   localparam logic [1:0] K_DIG = 2'b10;
   localparam logic [1:0] K_ERR = 2'b01;

   typedef struct packed {
      logic [1:0]  kind;
      logic [15:0] dig;
      logic [2:0]  cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  code_a = 8'h00, code_b = 8'h00;
   logic        valid_a = 1'b0, valid_b = 1'b0;
   logic [15:0] dig_a, dig_b;
   logic [2:0]  cnt_a, cnt_b;
   logic        dv_a, dv_b, err_a, err_b;

   int checks = 0;
   int errors = 0;
   exp_t q_a[$];
   exp_t q_b[$];

   always #5 clk = ~clk;

   scan_code_digit_buffer #(.NUM_DIGITS(4), .ACCEPT_KEYPAD(1)) u_a (
      .clk(clk), .rst(rst), .scan_code_in(code_a), .scan_valid_in(valid_a),
      .digits_out(dig_a), .count_out(cnt_a), .digit_valid_out(dv_a), .error_out(err_a));

   scan_code_digit_buffer #(.NUM_DIGITS(4), .ACCEPT_KEYPAD(0)) u_b (
      .clk(clk), .rst(rst), .scan_code_in(code_b), .scan_valid_in(valid_b),
      .digits_out(dig_b), .count_out(cnt_b), .digit_valid_out(dv_b), .error_out(err_b));

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s got %h required %h", name, got, req);
      end
   endtask

   always @(negedge clk) begin
      if (dv_a || err_a) begin
         if (q_a.size() == 0) begin
            chk("a_unexpected_pulse", {30'd0, dv_a, err_a}, 32'd0);
         end else begin
            exp_t e;
            e = q_a.pop_front();
            chk("a_pulse_kind", {30'd0, dv_a, err_a}, {30'd0, e.kind});
            chk("a_digits", {16'd0, dig_a}, {16'd0, e.dig});
            chk("a_count", {29'd0, cnt_a}, {29'd0, e.cnt});
         end
      end
   end

   always @(negedge clk) begin
      if (dv_b || err_b) begin
         if (q_b.size() == 0) begin
            chk("b_unexpected_pulse", {30'd0, dv_b, err_b}, 32'd0);
         end else begin
            exp_t e;
            e = q_b.pop_front();
            chk("b_pulse_kind", {30'd0, dv_b, err_b}, {30'd0, e.kind});
            chk("b_digits", {16'd0, dig_b}, {16'd0, e.dig});
            chk("b_count", {29'd0, cnt_b}, {29'd0, e.cnt});
         end
      end
   end

   // Strobes end one edge later, so consecutive calls give back-to-back strobes.
   task automatic sa(input logic [7:0] c);
      code_a = c; valid_a = 1'b1;
      @(posedge clk); #1;
      valid_a = 1'b0;
   endtask

   task automatic sb(input logic [7:0] c);
      code_b = c; valid_b = 1'b1;
      @(posedge clk); #1;
      valid_b = 1'b0;
   endtask

   task automatic ea(input logic [1:0] k, input logic [15:0] d, input logic [2:0] c);
      exp_t e;
      e.kind = k; e.dig = d; e.cnt = c;
      q_a.push_back(e);
   endtask

   task automatic eb(input logic [1:0] k, input logic [15:0] d, input logic [2:0] c);
      exp_t e;
      e.kind = k; e.dig = d; e.cnt = c;
      q_b.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_dig_a"}, {16'd0, dig_a}, 32'h0000FFFF);
      chk({tag, "_cnt_a"}, {29'd0, cnt_a}, 32'd0);
      chk({tag, "_pulse_a"}, {30'd0, dv_a, err_a}, 32'd0);
      chk({tag, "_dig_b"}, {16'd0, dig_b}, 32'h0000FFFF);
      chk({tag, "_cnt_b"}, {29'd0, cnt_b}, 32'd0);
      chk({tag, "_pulse_b"}, {30'd0, dv_b, err_b}, 32'd0);
   endtask

   initial begin
      idle(3);
      chk_reset_state("por");
      rst = 1'b0;
      idle(2);

      // Fill then overflow: oldest digit drops off, count saturates at 4.
      ea(K_DIG, 16'hFFF1, 3'd1); ea(K_DIG, 16'hFF12, 3'd2);
      ea(K_DIG, 16'hF123, 3'd3); ea(K_DIG, 16'h1234, 3'd4);
      ea(K_DIG, 16'h2345, 3'd4);
      sa(8'h16); sa(8'h1E); sa(8'h26); sa(8'h25); sa(8'h2E);
      idle(2);
      chk("fill_dig", {16'd0, dig_a}, 32'h00002345);

      // Asynchronous reset mid-run clears everything without a clock edge.
      rst = 1'b1;
      #1;
      chk_reset_state("mid_rst");
      idle(2);
      chk_reset_state("mid_rst_held");
      rst = 1'b0;
      idle(1);

      // Break sequence: the released key byte is swallowed.
      ea(K_DIG, 16'hFFF1, 3'd1);
      sa(8'h16); sa(8'hF0); sa(8'h16);
      idle(2);
      chk("break_dig", {16'd0, dig_a}, 32'h0000FFF1);
      chk("break_cnt", {29'd0, cnt_a}, 32'd1);

      // Esc with a non-empty buffer pulses; then E0 F0 70 is silent.
      ea(K_DIG, 16'hFFFF, 3'd0);
      ea(K_DIG, 16'hFFF0, 3'd1);
      sa(8'h76); sa(8'hE0); sa(8'hF0); sa(8'h70); sa(8'h70);
      eb(K_ERR, 16'hFFFF, 3'd0);
      eb(K_DIG, 16'hFFF0, 3'd1);
      sb(8'hE0); sb(8'hF0); sb(8'h70); sb(8'h70); sb(8'h45);
      idle(2);
      chk("kp_dig_a", {16'd0, dig_a}, 32'h0000FFF0);
      chk("nokp_dig_b", {16'd0, dig_b}, 32'h0000FFF0);

      // Backspace, clear, empty-buffer no-ops, unmapped codes.
      ea(K_DIG, 16'hFFFF, 3'd0);
      ea(K_DIG, 16'hFFF1, 3'd1); ea(K_DIG, 16'hFF12, 3'd2);
      ea(K_DIG, 16'hF123, 3'd3); ea(K_DIG, 16'h1234, 3'd4);
      ea(K_DIG, 16'hF123, 3'd3);
      ea(K_DIG, 16'hFFFF, 3'd0);
      ea(K_ERR, 16'hFFFF, 3'd0);
      ea(K_ERR, 16'hFFFF, 3'd0);
      ea(K_ERR, 16'hFFFF, 3'd0);
      sa(8'h76);
      sa(8'h16); sa(8'h1E); sa(8'h26); sa(8'h25);
      sa(8'h66); sa(8'h76); sa(8'h66); sa(8'h76);
      sa(8'h1C); sa(8'h00); sa(8'hFF);
      idle(2);
      chk("empty_cnt", {29'd0, cnt_a}, 32'd0);

      // Extended make is swallowed; typematic repeats count as new keys.
      ea(K_DIG, 16'hFFF7, 3'd1); ea(K_DIG, 16'hFF77, 3'd2);
      sa(8'hE0); sa(8'h16); sa(8'hE0); sa(8'hF0); sa(8'h16);
      sa(8'h3D); sa(8'h3D);
      idle(2);
      chk("typematic_dig", {16'd0, dig_a}, 32'h0000FF77);

      // Reset right after F0 discards the pending prefix.
      sa(8'hF0);
      rst = 1'b1;
      idle(1);
      chk_reset_state("prefix_rst");
      rst = 1'b0;
      idle(1);
      ea(K_DIG, 16'hFFF1, 3'd1);
      sa(8'h16);
      idle(2);
      chk("prefix_dig", {16'd0, dig_a}, 32'h0000FFF1);
      chk("prefix_cnt", {29'd0, cnt_a}, 32'd1);

      idle(3);
      chk("a_queue_left", q_a.size(), 32'd0);
      chk("b_queue_left", q_b.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
